pq_shift_array: RTL

- Shift-register hardware priority queue: sorted array of CAPACITY kv_t entries, minimum key at slot 0.
- Uses the shared kv_t struct, KV_EMPTY, PQ_CAPACITY, KEY_WIDTH and VAL_WIDTH from pq_pkg.
- Consumes enqueue/dequeue requests from the scheduler front-end and presents the current minimum-key entry to the downstream consumer.
- One operation per clock, no stalls; serves as the baseline HWPQ for the comparison study.

---
 rtl/pq_shift_array.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/pq_shift_array.sv
// -----------------------------------------------------------------------------
// pq_pkg / pq_shift_array
//
// Purpose:
//   Shift-register hardware priority queue. CAPACITY slots are kept sorted by
//   key with the minimum at slot 0. One operation per clock and no stalls. This
//   is the baseline priority queue used in the comparison study.
//
// Ports:
//   clk     in   1     rising-edge clock
//   rst     in   1     synchronous, active-high reset
//   enq     in   1     enqueue request
//   kvi     in   kv_t  entry to enqueue (valid when enq=1)
//   deq     in   1     dequeue request, removes the head
//   kvo     out  kv_t  current head (slot 0), KV_EMPTY when empty
//   count   out  CW    number of valid entries
//   full    out  1     count == CAPACITY
//   empty   out  1     count == 0
//   ovf     out  1     one-cycle pulse, enqueue rejected
//   unf     out  1     one-cycle pulse, dequeue rejected
//
// Optional feature (macro PQ_SHIFT_ARRAY_STATS_EN):
//   peak    out  CW    highest count reached since reset
//   err_cnt out  8     saturating count of ovf/unf pulses
// -----------------------------------------------------------------------------

package pq_pkg;
    localparam int KEY_WIDTH   = 8;
    localparam int VAL_WIDTH   = 8;
    localparam int PQ_CAPACITY = 15;

    localparam logic [KEY_WIDTH-1:0] KEYINF = '1;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } kv_t;

    localparam kv_t KV_EMPTY = '{key: KEYINF, val: '0};
endpackage

module pq_shift_array
    import pq_pkg::*;
#(
    parameter int CAPACITY = PQ_CAPACITY,
    parameter int CW       = $clog2(CAPACITY + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enq,
    input  kv_t           kvi,
    input  logic          deq,
    output kv_t           kvo,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          ovf,
`ifdef PQ_SHIFT_ARRAY_STATS_EN
    output logic [CW-1:0] peak,
    output logic [7:0]    err_cnt,
`endif
    output logic          unf
);

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_INSERT,
        OP_REMOVE,
        OP_REPLACE
    } op_e;

    kv_t           r_slot [CAPACITY];
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_unf;

    kv_t           w_left      [CAPACITY];
    kv_t           w_right     [CAPACITY];
    kv_t           w_slot_nxt  [CAPACITY];
    logic [CAPACITY-1:0] w_ins;
    logic [CAPACITY-1:0] w_ins_prev;
    logic [CAPACITY-1:0] w_rep;
    logic [CAPACITY-1:0] w_rep_prev;
    logic [CW-1:0] w_count_nxt;
    logic          w_full;
    logic          w_empty;
    logic          w_ovf;
    logic          w_unf;
    op_e           w_op;

    assign w_full  = (r_count == CW'(CAPACITY));
    assign w_empty = (r_count == '0);

    // Request decode. An enq+deq on an empty queue degrades to a plain insert
    // that still flags the rejected dequeue.
    // NOTE: every signal gets a default before the branches, otherwise a path
    // that does not assign it would infer a latch.
    always_comb begin
        w_op  = OP_HOLD;
        w_ovf = 1'b0;
        w_unf = 1'b0;
        if (enq && deq) begin
            if (w_empty) begin
                w_op  = OP_INSERT;
                w_unf = 1'b1;
            end else begin
                w_op  = OP_REPLACE;
            end
        end else if (enq) begin
            if (w_full) w_ovf = 1'b1;
            else        w_op  = OP_INSERT;
        end else if (deq) begin
            if (w_empty) w_unf = 1'b1;
            else         w_op  = OP_REMOVE;
        end
    end

    // Neighbour views of the array. w_left[0] is kvi so a shift-in at the head
    // needs no special case; the slot beyond the tail reads as KV_EMPTY.
    always_comb begin
        w_left[0] = kvi;
        for (int i = 1; i < CAPACITY; i++) begin
            w_left[i] = r_slot[i-1];
        end
        for (int i = 0; i < CAPACITY - 1; i++) begin
            w_right[i] = r_slot[i+1];
        end
        w_right[CAPACITY-1] = KV_EMPTY;
    end

    // One key comparison per slot. Strict less-than places a new entry behind
    // existing equal keys, giving FIFO order among ties. Validity comes from
    // the count so a KEYINF key is ordinary data. Because the array is sorted
    // both vectors are a run of zeros followed by ones; the first one marks
    // where kvi lands.
    always_comb begin
        for (int i = 0; i < CAPACITY; i++) begin
            w_ins[i] = (kvi.key < r_slot[i].key) || (CW'(i) >= r_count);
            // Replace compares against the array as it is after the head
            // leaves, i.e. against the right neighbour.
            w_rep[i] = (kvi.key < w_right[i].key) || (CW'(i + 1) >= r_count);
        end
    end

    assign w_ins_prev = {w_ins[CAPACITY-2:0], 1'b0};
    assign w_rep_prev = {w_rep[CAPACITY-2:0], 1'b0};

    // Per-slot next value: hold, left neighbour, right neighbour or kvi.
    always_comb begin
        w_count_nxt = r_count;
        for (int i = 0; i < CAPACITY; i++) begin
            w_slot_nxt[i] = r_slot[i];
        end
        unique case (w_op)
            OP_INSERT: begin
                w_count_nxt = r_count + CW'(1);
                for (int i = 0; i < CAPACITY; i++) begin
                    if (w_ins[i]) w_slot_nxt[i] = w_ins_prev[i] ? w_left[i] : kvi;
                end
            end
            OP_REMOVE: begin
                w_count_nxt = r_count - CW'(1);
                for (int i = 0; i < CAPACITY; i++) begin
                    w_slot_nxt[i] = w_right[i];
                end
            end
            OP_REPLACE: begin
                // Entries ahead of the insertion point move left into the
                // vacated head; entries behind it stay where they are.
                for (int i = 0; i < CAPACITY; i++) begin
                    if (!w_rep[i])          w_slot_nxt[i] = w_right[i];
                    else if (!w_rep_prev[i]) w_slot_nxt[i] = kvi;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the slot array is reset because empty slots must read as
            // KV_EMPTY on kvo and feed KV_EMPTY into the tail on shifts.
            for (int i = 0; i < CAPACITY; i++) begin
                r_slot[i] <= KV_EMPTY;
            end
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            for (int i = 0; i < CAPACITY; i++) begin
                r_slot[i] <= w_slot_nxt[i];
            end
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf;
            r_unf   <= w_unf;
        end
    end

`ifdef PQ_SHIFT_ARRAY_STATS_EN
    logic [CW-1:0] r_peak;
    logic [7:0]    r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_peak    <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_count_nxt > r_peak) r_peak <= w_count_nxt;
            if ((w_ovf || w_unf) && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign peak    = r_peak;
    assign err_cnt = r_err_cnt;
`endif

    assign kvo   = r_slot[0];
    assign count = r_count;
    assign full  = w_full;
    assign empty = w_empty;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule
